// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: command, response and APB signals between a requester and the APB bus
interface apb_master_bridge_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic              pslverr;
  logic [DATA_W-1:0] prdata;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, pready, pslverr, prdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, pready, pslverr, prdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command stream to APB SETUP/ACCESS transfers, one in flight.
// Define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT_CYCLES wait cycles.
module apb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                pclk,
  input  logic                presetn,
  apb_master_bridge_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_nxt;
  logic   accept, misaligned, done, timeout;
  assign accept     = state == IDLE && bus.cmd_valid;
  assign misaligned = bus.cmd_addr[1:0] != 2'b00;
  assign done       = state == ACCESS && bus.pready;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) cnt <= '0;
    else if (state != ACCESS) cnt <= '0;
    else if (!bus.pready) cnt <= cnt + 1'b1;
  // this cycle is the last allowed wait cycle; a pready arriving now still wins
  assign timeout = state == ACCESS && !bus.pready && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES == 0;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? (misaligned ? RESP : SETUP) : IDLE;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  state_nxt = done || timeout ? RESP : ACCESS;
      default: state_nxt = bus.rsp_ready ? IDLE : RESP;
    endcase
  end
  assign bus.cmd_ready = presetn && state == IDLE;
  assign bus.psel      = state == SETUP || state == ACCESS;
  assign bus.penable   = state == ACCESS;
  assign bus.rsp_valid = state == RESP;
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      bus.paddr     <= '0;
      bus.pwdata    <= '0;
      bus.pwrite    <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else if (accept) begin
      bus.paddr     <= bus.cmd_addr;
      bus.pwdata    <= bus.cmd_wdata;
      bus.pwrite    <= bus.cmd_write;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= misaligned;
    end else if (done || timeout) begin
      bus.rsp_err   <= !done || bus.pslverr;
      bus.rsp_rdata <= done && !bus.pwrite && !bus.pslverr ? bus.prdata : '0;
    end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream APB requester for the team's APB register slaves (number/date/surname/name register block at 0x0/0x4/0x8/0xC).
- Converts a simple valid/ready command stream from a local controller or testbench into APB SETUP/ACCESS transfers.
- Returns read data and error status on a valid/ready response channel.
- Handles one transfer in flight; wait states are supported by holding ACCESS until pready.

Parameters:
- ADDR_W, 32, width of cmd_addr and paddr.
- DATA_W, 32, width of write/read data.
- TIMEOUT_CYCLES, 16, ACCESS-phase cycle limit; used only when the optional feature is compiled in.

Ports:
- pclk  in  1  clock; all logic on rising edge.
- presetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge accepts command this cycle.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  transfer error.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pready  in  1  slave ready.
- pslverr  in  1  slave error.
- prdata  in  DATA_W  slave read data.

Behaviour:
- Interface: one clock, pclk; reset is asynchronous and active-low, presetn.
- Reset values: state IDLE.
  - psel, penable, pwrite, rsp_valid, rsp_err = 0.
  - paddr, pwdata, rsp_rdata = 0.
  - cmd_ready = 1 while presetn is high and state is IDLE.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch cmd_write, cmd_addr and cmd_wdata into paddr, pwrite and pwdata.
  - If cmd_addr[1:0] != 0 (misaligned): no bus transfer; go to RESP with rsp_err = 1 and rsp_rdata = 0.
  - Otherwise go to SETUP.
- SETUP (exactly 1 cycle): psel = 1, penable = 0; then go to ACCESS.
- ACCESS:
  - psel = 1, penable = 1.
  - paddr, pwrite and pwdata remain stable throughout SETUP and ACCESS.
  - At a rising edge with pready = 1:
    - Capture rsp_err = pslverr.
    - Capture rsp_rdata = prdata if read and no error, else 0.
    - Drop psel and penable; go to RESP.
  - pready = 0: remain in ACCESS indefinitely (unlimited wait states).
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready, clear rsp_valid and return to IDLE.
- pready, pslverr and prdata are sampled only when psel & penable; they are ignored in any other state.
- Latency, zero-wait slave:
  - Command accepted at edge 0; SETUP in cycle 1; ACCESS in cycle 2.
  - For a slave whose pready is registered (rises one cycle after penable), rsp_valid is first high in cycle 4.
- Next command is accepted only after the response handshake. psel is low for at least one cycle between transfers.
- cmd_ready is combinational from state only; it has no combinational path from cmd_valid.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronous). An in-flight command or pending response is discarded.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- With the macro:
  - An internal counter clears on entry to ACCESS and increments each ACCESS cycle with pready = 0.
  - When the count reaches TIMEOUT_CYCLES with no pready:
    - Drop psel and penable.
    - Go to RESP with rsp_err = 1 and rsp_rdata = 0.
    - Pulse internal status; no extra port.
  - pready arriving in the same cycle the limit is reached wins: normal completion.
- Without the macro: no counter logic is present, and ACCESS waits forever.

Test Plan:
- Write 0x0 <- 0x00000017 to a zero-wait slave:
  - Required: psel high for 2 cycles before pready; pwrite = 1; paddr = 0x0; pwdata = 0x00000017.
  - Response: rsp_valid with rsp_err = 0, rsp_rdata = 0.
- Write 0xC <- 0x4B415441, then read 0xC -> rsp_rdata = 0x4B415441, rsp_err = 0.
  - Required: psel low for at least 1 cycle between the two transfers.
- Read 0x10 from a slave that asserts pslverr -> rsp_err = 1, rsp_rdata = 0.
- Misaligned command cmd_addr = 0x6 -> psel never asserted; rsp_err = 1 within 2 cycles.
- Slave inserts 5 wait states; rsp_ready held low 3 cycles after rsp_valid:
  - Required: paddr and pwdata stable throughout; rsp_valid and rsp_rdata stable until the handshake; cmd_ready = 0 until the handshake.
- Reset and timeout cases:
  - presetn pulled low during ACCESS -> psel, penable and rsp_valid go 0 immediately; first command after reset completes normally.
  - With APB_MASTER_TIMEOUT_EN and pready stuck low -> rsp_err = 1 after 16 ACCESS cycles; psel dropped.
